// File: rtl/mem_access_responder.sv
// Single-port memory responder: sequences fetch/load/store requests onto a synchronous
// block RAM with WAIT_STATES extra read cycles. Optional address range check: MEM_ADDR_FAULT_EN.
module mem_access_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fetch,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [15:0]       instr_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              fetch_q, fetch_d;
  logic              we_q, we_d;
  logic              fault_q, fault_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic [15:0]       instr_d;
  logic [15:0]       rd_word;
  logic              addr_fault;

`ifdef MEM_ADDR_FAULT_EN
  assign addr_fault = (req_addr >> ADDR_W) != 16'd0;
  assign rsp_fault  = (state_q == S_RESP) && fault_q;
`else
  assign addr_fault = 1'b0;
  assign rsp_fault  = 1'b0;
`endif

  // A faulted read returns zero instead of whatever the aliased RAM word holds
  assign rd_word = fault_q ? 16'h0000 : ram_rdata;

  always_comb begin
    state_d     = state_q;
    fetch_d     = fetch_q;
    we_d        = we_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    instr_d     = instr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fetch_d     = req_fetch;
          we_d        = req_we & ~req_fetch;
          fault_d     = addr_fault;
          ram_addr_d  = req_addr[ADDR_W-1:0];
          ram_wdata_d = req_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = 3'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'(WAIT_STATES)) begin
          rsp_rdata_d = rd_word;
          if (fetch_q) instr_d = rd_word;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_q     <= 1'b0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= 3'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 16'h0000;
      rsp_rdata_q <= 16'h0000;
      instr_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      we_q        <= we_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      instr_q     <= instr_d;
    end
  end

  // Strobe decoded from state so an asynchronous reset drops it immediately
  assign ram_we    = (state_q == S_ISSUE) && we_q && !fault_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
